// File: rtl/mem_responder.sv
// Memory-side responder for the MEM_* bus: word-organised RAM with configurable wait states.
// Optional MEM_RESP_ALIGN_ERR_EN adds MEM_Err and rejects misaligned accesses instead of truncating them.
//
// state  | meaning
// IDLE   | ready for a command; command fields are latched on MEM_Cmd
// WAIT   | wait-state down-counter running; leaves at terminal count 0
// ACCESS | RAM read/write happens on the edge leaving this state
// RESP   | MEM_DataReady high for this single cycle
module mem_responder #(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        MEM_Ready,
    input  logic        MEM_Cmd,
    input  logic        MEM_We,
    input  logic [1:0]  MEM_ByteEnable,
    input  logic [31:0] MEM_Addr,
    input  logic [31:0] MEM_DataOut,
    output logic [31:0] MEM_DataIn,
    output logic        MEM_DataReady
`ifdef MEM_RESP_ALIGN_ERR_EN
    ,
    output logic        MEM_Err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} stateT;

    stateT       state;
    stateT       stateNext;
    logic [3:0]  waitCnt;
    logic        cmdAccept;

    logic        weQ;
    logic [1:0]  beQ;
    logic [AW+1:0] addrQ;
    logic [31:0] wdataQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic        dataReadyQ;
    logic [31:0] dataInQ;

    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [4:0]    shiftAmt;
    logic [3:0]    sizeMask;
    logic [3:0]    laneEn;
    logic [31:0]   dataMask;
    logic [31:0]   wdataAligned;
    logic [31:0]   readData;
    logic          memWrite;
    logic          unusedAddr;

    assign unusedAddr = ^MEM_Addr[31:AW+2];

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        MEM_Ready = 1'b0;
        cmdAccept = 1'b0;
        case (state)
            IDLE: begin
                MEM_Ready = 1'b1;
                if (MEM_Cmd) begin
                    cmdAccept = 1'b1;
                    stateNext = (LATENCY == 0) ? ACCESS : WAIT;
                end
            end
            WAIT:    if (waitCnt == 4'd0) stateNext = ACCESS;
            ACCESS:  stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Command fields are only consumed after IDLE, so they need no reset.
    always_ff @(posedge Clk) begin
        if (cmdAccept) begin
            weQ    <= MEM_We;
            beQ    <= MEM_ByteEnable;
            addrQ  <= MEM_Addr[AW+1:0];
            wdataQ <= MEM_DataOut;
        end
    end

    always_comb begin
        off      = addrQ[1:0];
        idx      = addrQ[AW+1:2];
        shiftAmt = {off, 3'b000};
        case (beQ)
            2'b00:   begin sizeMask = 4'b0001; dataMask = 32'h0000_00FF; end
            2'b01:   begin sizeMask = 4'b0011; dataMask = 32'h0000_FFFF; end
            default: begin sizeMask = 4'b1111; dataMask = 32'hFFFF_FFFF; end
        endcase
        // Lanes shifted past byte 3 fall off the word: misaligned accesses truncate.
        laneEn       = sizeMask << off;
        wdataAligned = wdataQ << shiftAmt;
        readData     = (mem[idx] >> shiftAmt) & dataMask;
    end

`ifdef MEM_RESP_ALIGN_ERR_EN
    logic misaligned;
    logic errQ;
    assign misaligned = ((beQ == 2'b01) && off[0]) || (beQ[1] && (off != 2'b00));
    assign memWrite   = (state == ACCESS) && weQ && !Reset && !misaligned;
    assign MEM_Err    = errQ;
`else
    assign memWrite   = (state == ACCESS) && weQ && !Reset;
`endif

    always_ff @(posedge Clk) begin
        if (memWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) mem[idx][8*i +: 8] <= wdataAligned[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            waitCnt    <= 4'd0;
            dataReadyQ <= 1'b0;
            dataInQ    <= 32'd0;
`ifdef MEM_RESP_ALIGN_ERR_EN
            errQ       <= 1'b0;
`endif
        end else begin
            dataReadyQ <= (state == ACCESS);
`ifdef MEM_RESP_ALIGN_ERR_EN
            errQ       <= (state == ACCESS) && misaligned;
`endif
            if (cmdAccept)
                waitCnt <= 4'((LATENCY > 0) ? LATENCY - 1 : 0);
            else if ((state == WAIT) && (waitCnt != 4'd0))
                waitCnt <= waitCnt - 4'd1;
            if ((state == ACCESS) && !weQ) begin
`ifdef MEM_RESP_ALIGN_ERR_EN
                dataInQ <= misaligned ? 32'd0 : readData;
`else
                dataInQ <= readData;
`endif
            end
        end
    end

    assign MEM_DataIn    = dataInQ;
    assign MEM_DataReady = dataReadyQ;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance A runs LATENCY=1, instance B runs LATENCY=3.
// Build with MEM_RESP_ALIGN_ERR_EN defined to exercise the misalignment-error variant.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, cmdA, weA, rdyA, drA;
    logic [1:0]  beA;
    logic [31:0] addrA, doA, diA;
    logic        rstB, cmdB, weB, rdyB, drB;
    logic [1:0]  beB;
    logic [31:0] addrB, doB, diB;
`ifdef MEM_RESP_ALIGN_ERR_EN
    logic        errA, errB;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    mem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) uA (
        .Clk(clk), .Reset(rstA), .MEM_Ready(rdyA), .MEM_Cmd(cmdA), .MEM_We(weA),
        .MEM_ByteEnable(beA), .MEM_Addr(addrA), .MEM_DataOut(doA),
        .MEM_DataIn(diA), .MEM_DataReady(drA)
`ifdef MEM_RESP_ALIGN_ERR_EN
        , .MEM_Err(errA)
`endif
    );

    mem_responder #(.DEPTH_WORDS(4096), .LATENCY(3)) uB (
        .Clk(clk), .Reset(rstB), .MEM_Ready(rdyB), .MEM_Cmd(cmdB), .MEM_We(weB),
        .MEM_ByteEnable(beB), .MEM_Addr(addrB), .MEM_DataOut(doB),
        .MEM_DataIn(diB), .MEM_DataReady(drB)
`ifdef MEM_RESP_ALIGN_ERR_EN
        , .MEM_Err(errB)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic cmd, input logic we, input logic [1:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            cmdA = cmd; weA = we; beA = be; addrA = addr; doA = wd;
        end else begin
            cmdB = cmd; weB = we; beB = be; addrB = addr; doB = wd;
        end
    endtask

    // Issues one command in the current cycle; lat = cycles from Cmd cycle to DataReady cycle.
    task automatic xfer(input int sel, input logic we, input logic [1:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
        drive(sel, 1'b1, we, be, addr, wd);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        lat = -1;
        err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (((sel == 0) ? drA : drB) === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        rd = (sel == 0) ? diA : diB;
`ifdef MEM_RESP_ALIGN_ERR_EN
        err = (sel == 0) ? errA : errB;
`endif
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [8:0]  readyVec;
        logic [8:0]  drVec;

        rstA = 1'b1; rstB = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        rstA = 1'b0; rstB = 1'b0;
        @(negedge clk);

        checkVal("rst_readyA", {31'd0, rdyA}, 32'd1);
        checkVal("rst_drA",    {31'd0, drA},  32'd0);
        checkVal("rst_dataInA", diA, 32'd0);
        checkVal("rst_readyB", {31'd0, rdyB}, 32'd1);

        // Basic word write/read with LATENCY=1
        xfer(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, err, lat);
        checkVal("t1_wr_lat", lat, 32'd3);
        checkVal("t1_wr_dataIn_held", rd, 32'd0);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'd0, rd, err, lat);
        checkVal("t1_rd_lat", lat, 32'd3);
        checkVal("t1_rd_word", rd, 32'hDEADBEEF);

        // Sub-word reads and byte write
        xfer(0, 1'b0, 2'b01, 32'h12, 32'd0, rd, err, lat);
        checkVal("t2_half_0x12", rd, 32'h0000DEAD);
        xfer(0, 1'b0, 2'b00, 32'h11, 32'd0, rd, err, lat);
        checkVal("t2_byte_0x11", rd, 32'h000000BE);
        xfer(0, 1'b1, 2'b00, 32'h13, 32'hFFFFFFAA, rd, err, lat);
        checkVal("t2_bytewr_dataIn_held", rd, 32'h000000BE);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'd0, rd, err, lat);
        checkVal("t2_word_after_byte", rd, 32'hAAADBEEF);
        xfer(0, 1'b0, 2'b11, 32'h10, 32'd0, rd, err, lat);
        checkVal("t2_be11_word", rd, 32'hAAADBEEF);

`ifdef MEM_RESP_ALIGN_ERR_EN
        xfer(0, 1'b1, 2'b10, 32'h11, 32'h11111111, rd, err, lat);
        checkVal("t6_mis_wr_err", {31'd0, err}, 32'd1);
        checkVal("t6_mis_wr_lat", lat, 32'd3);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'd0, rd, err, lat);
        checkVal("t6_ram_unchanged", rd, 32'hAAADBEEF);
        checkVal("t6_aligned_no_err", {31'd0, err}, 32'd0);
        xfer(0, 1'b0, 2'b01, 32'h13, 32'd0, rd, err, lat);
        checkVal("t6_mis_rd_data", rd, 32'd0);
        checkVal("t6_mis_rd_err", {31'd0, err}, 32'd1);
`else
        xfer(0, 1'b0, 2'b10, 32'h11, 32'd0, rd, err, lat);
        checkVal("t6_mis_word_rd", rd, 32'h00AAADBE);
        xfer(0, 1'b0, 2'b01, 32'h13, 32'd0, rd, err, lat);
        checkVal("t6_mis_half_rd", rd, 32'h000000AA);
        xfer(0, 1'b1, 2'b01, 32'h13, 32'h00001234, rd, err, lat);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'd0, rd, err, lat);
        checkVal("t6_mis_half_wr", rd, 32'h34ADBEEF);
`endif

        // Address aliasing above the RAM depth
        xfer(0, 1'b1, 2'b10, 32'h4010, 32'hCAFEF00D, rd, err, lat);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'd0, rd, err, lat);
        checkVal("t5_alias", rd, 32'hCAFEF00D);

        // Reset landing on the ACCESS edge drops the write
        xfer(0, 1'b1, 2'b10, 32'h30, 32'h55555555, rd, err, lat);
        drive(0, 1'b1, 1'b1, 2'b10, 32'h30, 32'hFFFFFFFF);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        rstA = 1'b1;
        @(negedge clk);
        rstA = 1'b0;
        checkVal("rstacc_ready", {31'd0, rdyA}, 32'd1);
        checkVal("rstacc_dr", {31'd0, drA}, 32'd0);
        xfer(0, 1'b0, 2'b10, 32'h30, 32'd0, rd, err, lat);
        checkVal("rstacc_ram_kept", rd, 32'h55555555);

        // LATENCY=3 timing with an ignored second command
        drive(1, 1'b1, 1'b0, 2'b10, 32'h0, 32'd0);
        readyVec[0] = rdyB;
        drVec[0] = drB;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            drive(1, (c == 2), 1'b0, 2'b10, 32'h0, 32'd0);
            readyVec[c] = rdyB;
            drVec[c] = drB;
        end
        checkVal("t3_ready_seq", {23'd0, readyVec}, {23'd0, 9'b111000001});
        checkVal("t3_dr_seq", {23'd0, drVec}, {23'd0, 9'b000100000});
        xfer(1, 1'b1, 2'b10, 32'h20, 32'h0BADF00D, rd, err, lat);
        checkVal("t3_wr_lat", lat, 32'd5);

        // Reset during WAIT cancels the pending write
        drive(1, 1'b1, 1'b1, 2'b10, 32'h20, 32'h12345678);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        rstB = 1'b1;
        @(negedge clk);
        rstB = 1'b0;
        checkVal("t4_ready_after_rst", {31'd0, rdyB}, 32'd1);
        repeat (6) begin
            @(negedge clk);
        end
        checkVal("t4_no_dr", {31'd0, drB}, 32'd0);
        xfer(1, 1'b0, 2'b10, 32'h20, 32'd0, rd, err, lat);
        checkVal("t4_prior_contents", rd, 32'h0BADF00D);
        checkVal("t4_rd_lat", lat, 32'd5);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
